// File: rtl/irq_pkg.sv
// Shared types and helpers for the interrupt arbiter.
// Source index i is presented to the core as ID i+1. ID 0 means "no interrupt".
package irq_pkg;

  localparam int PRIO_W_DEF = 3;
  localparam int ID_NONE    = 0;

  typedef enum logic {
    IDLE    = 1'b0,
    SERVING = 1'b1
  } irqState_t;

  function automatic int idx_to_id(input int idx);
    return idx + 1;
  endfunction

  function automatic int id_to_idx(input int id);
    return id - 1;
  endfunction

endpackage

// File: rtl/irq_arbiter_if.sv
// Core-side interrupt handshake: request/ID out, claim/complete strobes in.
interface irq_arbiter_if #(
  parameter int ID_W = 4
) ();

  logic            Claim;
  logic [ID_W-1:0] ClaimId;
  logic            Complete;
  logic [ID_W-1:0] CompleteId;
  logic            Int;
  logic [ID_W-1:0] IntId;

  modport master (
    output Claim,
    output Complete,
    output CompleteId,
    input  ClaimId,
    input  Int,
    input  IntId
  );

  modport slave (
    input  Claim,
    input  Complete,
    input  CompleteId,
    output ClaimId,
    output Int,
    output IntId
  );

endinterface

// File: rtl/irq_gateway.sv
// Per-source request gateway: latches a level or rising-edge request into Pending.
// Requests arriving while pending or in service are dropped, not queued.
module irq_gateway (
  input  logic Clk,
  input  logic ResetN,
  input  logic Src,
  input  logic EdgeMode,
  input  logic SetBlock,
  input  logic ClaimClear,
  output logic Pending
);

  logic srcPrev;
  logic trigger;

  always_comb begin
    trigger = EdgeMode ? (Src & ~srcPrev) : Src;
  end

  always_ff @(posedge Clk or negedge ResetN) begin
    if (!ResetN) begin
      srcPrev <= 1'b0;
      Pending <= 1'b0;
    end else begin
      srcPrev <= Src;
      // Claim wins over a simultaneous request on the claimed source.
      if (ClaimClear) begin
        Pending <= 1'b0;
      end else if (!Pending && !SetBlock && trigger) begin
        Pending <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/irq_arbiter.sv
// Platform interrupt arbiter: gateways, priority selection and claim/complete FSM.
//   state   | meaning
//   IDLE    | Int/IntId show the best eligible source (registered)
//   SERVING | one source claimed; Int held low until its matching Complete
module irq_arbiter
  import irq_pkg::*;
#(
  parameter int NUM_SRC = 8,
  parameter int PRIO_W  = PRIO_W_DEF,
  parameter int ID_W    = 4
) (
  input  logic                      Clk,
  input  logic                      ResetN,
  input  logic [NUM_SRC-1:0]        Src,
  input  logic [NUM_SRC-1:0]        EdgeMode,
  input  logic [NUM_SRC-1:0]        EnMask,
  input  logic [NUM_SRC*PRIO_W-1:0] Priority,
  input  logic [PRIO_W-1:0]         Threshold,
  irq_arbiter_if.slave              Core,
  output logic [NUM_SRC-1:0]        Pending,
  output logic [NUM_SRC-1:0]        InService
);

  irqState_t          state;
  logic [ID_W-1:0]    servId;
  logic [ID_W-1:0]    intIdReg;
  logic [ID_W-1:0]    claimIdReg;
  logic               intReg;

  logic [NUM_SRC-1:0] eligible;
  logic [NUM_SRC-1:0] claimClear;
  logic               anyElig;
  logic [PRIO_W-1:0]  bestPrio;
  logic [ID_W-1:0]    bestId;
  logic               claimAccept;
  logic               completeMatch;

  for (genvar g = 0; g < NUM_SRC; g++) begin : gen_gateway
    irq_gateway u_gateway (
      .Clk        (Clk),
      .ResetN     (ResetN),
      .Src        (Src[g]),
      .EdgeMode   (EdgeMode[g]),
      .SetBlock   (InService[g]),
      .ClaimClear (claimClear[g]),
      .Pending    (Pending[g])
    );
  end

  always_comb begin
    eligible = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      eligible[i] = Pending[i] & EnMask[i] & ~InService[i] &
                    (Priority[i*PRIO_W +: PRIO_W] > Threshold);
    end
  end

  // Strict '>' keeps the lowest index on a priority tie.
  always_comb begin
    anyElig  = 1'b0;
    bestPrio = '0;
    bestId   = ID_W'(ID_NONE);
    for (int i = 0; i < NUM_SRC; i++) begin
      if (eligible[i] && (!anyElig || (Priority[i*PRIO_W +: PRIO_W] > bestPrio))) begin
        anyElig  = 1'b1;
        bestPrio = Priority[i*PRIO_W +: PRIO_W];
        bestId   = ID_W'(idx_to_id(i));
      end
    end
  end

  always_comb begin
    claimAccept   = Core.Claim && (state == IDLE) && (intIdReg != ID_W'(ID_NONE));
    completeMatch = Core.Complete && (state == SERVING) && (Core.CompleteId == servId);
  end

  always_comb begin
    claimClear = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      claimClear[i] = claimAccept && (intIdReg == ID_W'(idx_to_id(i)));
    end
  end

  always_ff @(posedge Clk or negedge ResetN) begin
    if (!ResetN) begin
      state      <= IDLE;
      InService  <= '0;
      servId     <= ID_W'(ID_NONE);
      intReg     <= 1'b0;
      intIdReg   <= ID_W'(ID_NONE);
      claimIdReg <= ID_W'(ID_NONE);
    end else begin
      case (state)
        IDLE: begin
          if (Core.Claim) begin
            claimIdReg <= intIdReg;
          end
          if (claimAccept) begin
            state     <= SERVING;
            InService <= claimClear;
            servId    <= intIdReg;
            intReg    <= 1'b0;
            intIdReg  <= ID_W'(ID_NONE);
          end else begin
            intReg    <= anyElig;
            intIdReg  <= bestId;
          end
        end
        SERVING: begin
          intReg   <= 1'b0;
          intIdReg <= ID_W'(ID_NONE);
          if (Core.Claim) begin
            claimIdReg <= ID_W'(ID_NONE);
          end
          if (completeMatch) begin
            state     <= IDLE;
            InService <= '0;
            servId    <= ID_W'(ID_NONE);
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign Core.Int     = intReg;
  assign Core.IntId   = intIdReg;
  assign Core.ClaimId = claimIdReg;

endmodule

// File: tb/tb_irq_arbiter.sv
// Bench for irq_arbiter: selection vectors, handshake sequences, and random
// traffic checked against a queue-free behavioural model of the arbiter.
module tb_irq_arbiter;

  logic        Clk = 1'b0;
  logic        ResetN = 1'b0;
  logic [7:0]  Src = '0;
  logic [7:0]  EdgeMode = '0;
  logic [7:0]  EnMask = '0;
  logic [23:0] Priority = '0;
  logic [2:0]  Threshold = '0;
  logic [7:0]  Pending;
  logic [7:0]  InService;

  int nChecks = 0;
  int nPass = 0;

  irq_arbiter_if #(.ID_W(4)) coreIf ();

  irq_arbiter #(.NUM_SRC(8), .PRIO_W(3), .ID_W(4)) dut (
    .Clk       (Clk),
    .ResetN    (ResetN),
    .Src       (Src),
    .EdgeMode  (EdgeMode),
    .EnMask    (EnMask),
    .Priority  (Priority),
    .Threshold (Threshold),
    .Core      (coreIf),
    .Pending   (Pending),
    .InService (InService)
  );

  always #5 Clk = ~Clk;

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached, got no finish, required finish");
    $fatal(1, "watchdog");
  end

  // Behavioural model: mSvc is the in-service source index (-1 = none).
  logic [7:0] mPend = '0;
  logic [7:0] mPrev = '0;
  int mSvc = -1;
  int mInt = 0;
  int mIntId = 0;
  int mClaimId = 0;

  task automatic modelReset();
    mPend = '0; mPrev = '0; mSvc = -1; mInt = 0; mIntId = 0; mClaimId = 0;
  endtask

  task automatic modelStep();
    int bestKey, bestId, clearIdx, newSvc;
    logic [7:0] trig, svcMask, newPend;
    bestKey = -1; bestId = 0; clearIdx = -1; newSvc = mSvc;
    for (int i = 0; i < 8; i++) begin
      int p;
      p = int'(Priority[3*i +: 3]);
      if (mPend[i] && EnMask[i] && mSvc != i && p > int'(Threshold) &&
          (p * 16 + (15 - i)) > bestKey) begin
        bestKey = p * 16 + (15 - i);
        bestId  = i + 1;
      end
    end
    if (mSvc < 0) begin
      if (coreIf.Claim) begin
        mClaimId = mIntId;
        if (mIntId != 0) begin
          clearIdx = mIntId - 1;
          newSvc   = clearIdx;
        end
      end
      mInt   = (newSvc < 0 && bestKey >= 0) ? 1 : 0;
      mIntId = (newSvc < 0) ? bestId : 0;
    end else begin
      if (coreIf.Claim) mClaimId = 0;
      if (coreIf.Complete && int'(coreIf.CompleteId) == mSvc + 1) newSvc = -1;
      mInt = 0; mIntId = 0;
    end
    trig    = (EdgeMode & Src & ~mPrev) | (~EdgeMode & Src);
    svcMask = (mSvc >= 0) ? (8'h01 << mSvc) : 8'h00;
    newPend = mPend | (trig & ~svcMask);
    if (clearIdx >= 0) newPend[clearIdx] = 1'b0;
    mPend = newPend;
    mPrev = Src;
    mSvc  = newSvc;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nChecks++;
    if (act === exp) nPass++;
    else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  task automatic tick();
    @(posedge Clk);
    modelStep();
    #1;
  endtask

  task automatic doReset();
    ResetN = 1'b0;
    Src = '0;
    coreIf.Claim = 1'b0;
    coreIf.Complete = 1'b0;
    #1;
    modelReset();
    @(negedge Clk);
    ResetN = 1'b1;
  endtask

  task automatic claim();
    coreIf.Claim = 1'b1;
    tick();
    coreIf.Claim = 1'b0;
  endtask

  task automatic complete(input int id);
    coreIf.Complete = 1'b1;
    coreIf.CompleteId = 4'(id);
    tick();
    coreIf.Complete = 1'b0;
  endtask

  task automatic pulse(input logic [7:0] s);
    Src = s;
    tick();
    Src = '0;
    tick();
  endtask

  function automatic logic [23:0] pset(input int idx, input int val);
    return 24'(val) << (3 * idx);
  endfunction

  typedef struct {
    logic [7:0]  src;
    logic [7:0]  en;
    logic [23:0] prio;
    logic [2:0]  thr;
    logic        expInt;
    logic [3:0]  expId;
  } vec_t;

  vec_t vecs[9];

  initial begin
    coreIf.Claim = 1'b0;
    coreIf.Complete = 1'b0;
    coreIf.CompleteId = '0;

    vecs[0] = '{8'h08, 8'hFF, pset(3, 5), 3'd2, 1'b1, 4'd4};
    vecs[1] = '{8'h42, 8'hFF, pset(1, 3) | pset(6, 3), 3'd0, 1'b1, 4'd2};
    vecs[2] = '{8'h42, 8'hFF, pset(1, 3) | pset(6, 7), 3'd0, 1'b1, 4'd7};
    vecs[3] = '{8'h01, 8'hFF, pset(0, 2), 3'd2, 1'b0, 4'd0};
    vecs[4] = '{8'h01, 8'hFF, pset(0, 2), 3'd1, 1'b1, 4'd1};
    vecs[5] = '{8'hFF, 8'h7E, 24'o44444444, 3'd0, 1'b1, 4'd2};
    vecs[6] = '{8'h80, 8'h7F, pset(7, 7), 3'd0, 1'b0, 4'd0};
    vecs[7] = '{8'h00, 8'hFF, 24'o77777777, 3'd0, 1'b0, 4'd0};
    vecs[8] = '{8'h81, 8'hFF, pset(0, 1) | pset(7, 1), 3'd0, 1'b1, 4'd1};

    modelReset();
    #12;
    ResetN = 1'b1;
    tick();
    chk("reset_int", coreIf.Int, 0);
    chk("reset_claimid", coreIf.ClaimId, 0);
    chk("reset_pending", Pending, 0);

    for (int v = 0; v < 9; v++) begin
      doReset();
      EdgeMode = '0; EnMask = vecs[v].en; Priority = vecs[v].prio; Threshold = vecs[v].thr;
      pulse(vecs[v].src);
      chk($sformatf("vec%0d_int", v), coreIf.Int, vecs[v].expInt);
      chk($sformatf("vec%0d_id", v), coreIf.IntId, vecs[v].expId);
    end

    // Level pulse, claim/complete, wrong and overlapping handshakes
    doReset();
    EdgeMode = '0; EnMask = 8'hFF; Priority = pset(3, 5); Threshold = 3'd2;
    pulse(8'h08);
    chk("pulse_int", coreIf.Int, 1);
    chk("pulse_id", coreIf.IntId, 4);
    tick();
    chk("pulse_hold_id", coreIf.IntId, 4);
    claim();
    chk("claim_id", coreIf.ClaimId, 4);
    chk("claim_int", coreIf.Int, 0);
    chk("claim_insvc", InService, 8'h08);
    chk("claim_pend", Pending, 0);
    complete(3);
    chk("wrongcmp_insvc", InService, 8'h08);
    claim();
    chk("svc_claim_id", coreIf.ClaimId, 0);
    coreIf.Claim = 1'b1; coreIf.Complete = 1'b1; coreIf.CompleteId = 4'd4;
    tick();
    coreIf.Claim = 1'b0; coreIf.Complete = 1'b0;
    chk("both_insvc", InService, 0);
    chk("both_claimid", coreIf.ClaimId, 0);
    tick();
    chk("both_int", coreIf.Int, 0);
    pulse(8'h08);
    claim();
    chk("reclaim_id", coreIf.ClaimId, 4);
    complete(4);
    chk("cmp_insvc", InService, 0);
    tick();
    chk("cmp_int_low", coreIf.Int, 0);
    claim();
    chk("empty_claim_id", coreIf.ClaimId, 0);

    // Masking and priority lowering while pending
    pulse(8'h08);
    EnMask = 8'hF7;
    tick();
    chk("mask_int", coreIf.Int, 0);
    chk("mask_pend", Pending, 8'h08);
    EnMask = 8'hFF;
    tick();
    chk("unmask_id", coreIf.IntId, 4);
    Priority = pset(3, 2);
    tick();
    chk("lowprio_int", coreIf.Int, 0);
    Priority = pset(3, 5);
    tick();
    chk("restore_int", coreIf.Int, 1);
    claim();
    complete(4);

    // Level re-pend after complete, then reset while serving
    doReset();
    Priority = pset(2, 3); Threshold = 3'd0;
    Src = 8'h04;
    tick(); tick();
    chk("lvl_id", coreIf.IntId, 3);
    claim();
    tick();
    chk("lvl_blocked_pend", Pending, 0);
    complete(3);
    chk("lvl_cmp_insvc", InService, 0);
    tick();
    chk("lvl_repend", Pending, 8'h04);
    tick();
    chk("lvl_reint_id", coreIf.IntId, 3);
    claim();
    chk("lvl_svc2", InService, 8'h04);
    ResetN = 1'b0;
    #1;
    chk("rst_insvc", InService, 0);
    chk("rst_int", coreIf.Int, 0);
    chk("rst_claimid", coreIf.ClaimId, 0);
    chk("rst_pend", Pending, 0);
    Src = '0;
    modelReset();
    @(negedge Clk);
    ResetN = 1'b1;
    tick(); tick(); tick();
    chk("postrst_int", coreIf.Int, 0);
    pulse(8'h04);
    chk("postrst_new_id", coreIf.IntId, 3);

    // Edge mode: edges during service are dropped
    doReset();
    EdgeMode = 8'h20; EnMask = 8'hFF; Priority = pset(5, 6); Threshold = 3'd0;
    pulse(8'h20);
    chk("edge_id", coreIf.IntId, 6);
    claim();
    chk("edge_insvc", InService, 8'h20);
    Src = 8'h20; tick(); Src = 8'h00; tick(); Src = 8'h20; tick();
    chk("edge_drop_pend", Pending, 0);
    complete(6);
    tick(); tick();
    chk("edge_no_repend", Pending, 0);
    chk("edge_no_int", coreIf.Int, 0);
    Src = 8'h00; tick();
    Src = 8'h20; tick();
    chk("edge_new_pend", Pending, 8'h20);
    Src = 8'h00; tick();
    chk("edge_new_id", coreIf.IntId, 6);

    // Random traffic against the model
    doReset();
    for (int c = 0; c < 3000; c++) begin
      if (c % 60 == 0) begin
        EdgeMode  = 8'($urandom);
        EnMask    = 8'($urandom) | 8'($urandom);
        Priority  = 24'($urandom);
        Threshold = 3'($urandom_range(0, 3));
      end
      Src = 8'($urandom) & 8'($urandom) & 8'($urandom);
      coreIf.Claim = (($urandom % 5) == 0);
      coreIf.Complete = (($urandom % 4) == 0);
      coreIf.CompleteId = (($urandom % 2) == 0) ? 4'(mSvc + 1) : 4'($urandom);
      tick();
      chk("rnd_int", coreIf.Int, mInt);
      chk("rnd_intid", coreIf.IntId, mIntId);
      chk("rnd_claimid", coreIf.ClaimId, mClaimId);
      chk("rnd_pend", Pending, mPend);
      chk("rnd_insvc", InService, (mSvc >= 0) ? (8'h01 << mSvc) : 8'h00);
    end
    coreIf.Claim = 1'b0;
    coreIf.Complete = 1'b0;

    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

endmodule

// File: doc/irq_arbiter.md
Name: irq_arbiter

Overview:
- Platform-level interrupt arbiter that shares the core's interrupt input among NUM_SRC peripheral requesters.
- Latches requests per source through a level/edge gateway.
- Selects the highest-priority enabled pending source above a threshold and presents it to the core.
- Claim/complete handshake with a single in-service interrupt at a time. Int/IntId drive one source input of the core-local interrupt controller.

Parameters:
NUM_SRC, 8, number of interrupt sources (1..15)
PRIO_W, 3, priority field width; priority 0 = never interrupt
ID_W, 4, interrupt ID width; ID 0 reserved = "no interrupt", source i has ID i+1

Ports:
Clk  in  1  system clock, all state on rising edge
ResetN  in  1  asynchronous active-low reset
Src  in  NUM_SRC  raw interrupt request lines, active high
EdgeMode  in  NUM_SRC  per source: 1 = rising-edge triggered, 0 = level triggered
EnMask  in  NUM_SRC  per-source enable
Priority  in  NUM_SRC*PRIO_W  packed priorities, source i at [i*PRIO_W +: PRIO_W]
Threshold  in  PRIO_W  only priority > Threshold may interrupt
Claim  in  1  single-cycle claim strobe from core
ClaimId  out  ID_W  ID returned by last claim, held until next Claim
Complete  in  1  single-cycle completion strobe
CompleteId  in  ID_W  ID being completed
Int  out  1  interrupt request to core
IntId  out  ID_W  ID of currently selected source (0 if none)
Pending  out  NUM_SRC  latched pending bits
InService  out  NUM_SRC  one-hot (or zero) in-service source

Behaviour:
- Reset (ResetN low, async): Pending, InService, edge-sample regs, Int, IntId, ClaimId all 0; FSM = IDLE.
- Gateway, level mode: Pending[i] sets when Src[i]=1, Pending[i]=0 and InService[i]=0. Once set, it stays set even if Src drops; it clears only on claim.
- Gateway, edge mode: Src sampled each cycle. A rising edge (Src=1, prev=0) sets Pending[i] if Pending[i]=0 and InService[i]=0; otherwise the edge is dropped.
- Eligibility: Pending & EnMask & ~InService, Priority > Threshold.
- Selection: highest priority wins; on a tie, the lowest index wins.
- Int/IntId are registered: 1 cycle latency from a Pending/config change to output.
- FSM IDLE: Int = (eligible exists), IntId = best ID. Int forced 0, IntId 0 in SERVING.
- Claim in IDLE:
  - ClaimId <= current registered IntId.
  - If IntId != 0: Pending clear, InService set for that source, FSM -> SERVING, Int drops next cycle.
  - If IntId == 0: ClaimId <= 0 and FSM stays IDLE.
- Claim in SERVING: ClaimId <= 0, no state change.
- Complete in SERVING with CompleteId matching the in-service ID: InService cleared, FSM -> IDLE. Int may reassert on the following cycle.
- Complete with non-matching ID, or while IDLE: ignored.
- Claim and Complete in the same cycle:
  - Complete is evaluated first against the current state; the Claim then sees the pre-cycle FSM state.
  - In SERVING, a matching Complete goes to IDLE and ClaimId <= 0.
  - In IDLE, Claim is processed and Complete is ignored.
- EnMask cleared or Priority lowered while pending: Pending retained, source becomes ineligible. Re-enabling makes it eligible again.
- A source asserting in the same cycle as a Claim becomes pending normally; it is visible in IntId one cycle later.
- Level source still high after Complete: re-pends on the next cycle.

Decomposition:
- Package irq_pkg: ID_NONE = 0, state enum {IDLE, SERVING}, default PRIO_W, function idx_to_id/id_to_idx.
- Sub-module irq_gateway (one per source, generate loop):
  - Inputs: Src, EdgeMode, set-block (InService), claim-clear.
  - Outputs: Pending bit.
- Priority selection and FSM stay in irq_arbiter.

Test Plan:
- Reset mid-SERVING (ResetN low while InService[2]=1) -> all outputs 0 immediately, FSM IDLE; after release, no Int until a new request arrives.
- Src[3] level pulse 1 cycle, Priority[3]=5, Threshold=2, EnMask=all:
  - Int=1, IntId=4 two cycles after the pulse, held after Src drops.
  - Claim -> ClaimId=4, Int=0, InService=0x08.
  - Complete(4) -> IDLE, Int stays 0.
- Src[1] and Src[6] both pending with priorities 3 and 3 -> IntId=2. With Priority[6]=7 instead -> IntId=7.
- Priority[0]=2, Threshold=2, Src[0] high -> Int stays 0. Set Threshold=1 -> Int=1, IntId=1 next cycle.
- Edge mode on source 5: two rising edges while in service -> both dropped. After Complete(6), no re-pend unless a new edge arrives.
- Wrong and overlapping handshakes:
  - SERVING ID 4: Complete(3) -> still SERVING; Claim -> ClaimId=0.
  - Claim+Complete(4) in the same cycle -> IDLE, ClaimId=0.
  - Claim with no eligible source -> ClaimId=0.
